// File: rtl/reg_init_seq.sv
// Boot-time register initialiser: walks INIT_TABLE once and writes each
// {addr, data} entry to an APB slave, with a gap and timeout per transfer.
module reg_init_seq #(
   parameter int          N_INIT_REG     = 38,
   parameter logic [63:0] INIT_TABLE [(N_INIT_REG > 0) ? N_INIT_REG : 1] = '{default: 64'h0},
   parameter int          GAP_CYCLES     = 4,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        i_apb_clk,
   input  logic        i_apb_rst,
   input  logic        i_start,
   output logic        o_psel,
   output logic        o_penable,
   output logic        o_pwrite,
   output logic [31:0] o_paddr,
   output logic [31:0] o_pwdata,
   output logic [3:0]  o_pstrb,
   input  logic        i_pready,
   input  logic        i_pslverr,
   output logic        o_busy,
   output logic        o_init_done,
   output logic        o_init_err,
   output logic [7:0]  o_err_idx
);

   localparam int N_TAB  = (N_INIT_REG > 0) ? N_INIT_REG : 1;
   localparam int IDX_W  = (N_INIT_REG > 1) ? $clog2(N_INIT_REG) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int N_LAST = (N_INIT_REG > 0) ? N_INIT_REG - 1 : 0;
   localparam int G_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam int T_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [TO_W-1:0]    r_acc_cnt;
   logic               r_psel;
   logic               r_penable;
   logic               r_pwrite;
   logic [31:0]        r_paddr;
   logic [31:0]        r_pwdata;
   logic [3:0]         r_pstrb;
   logic               r_busy;
   logic               r_init_done;
   logic               r_init_err;
   logic [7:0]         r_err_idx;
   logic [IDX_W-1:0]   w_load_idx;
   logic [63:0]        w_entry;

   // Bounded table lookup: indices past the end of the table read as zero.
   function automatic logic [63:0] f_entry(input logic [IDX_W-1:0] k);
      logic [63:0] v;
      v = 64'h0;
      for (int i = 0; i < N_TAB; i++) begin
         if (IDX_W'(i) == k) begin
            v = INIT_TABLE[i];
         end else begin
            v = v;
         end
      end
      return v;
   endfunction

   // Entry that the next SETUP will present: 0 from IDLE, idx+1 straight out of ACCESS.
   always_comb begin
      w_load_idx = r_idx;
      if (r_state == ST_IDLE) begin
         w_load_idx = '0;
      end else if (r_state == ST_ACCESS) begin
         w_load_idx = r_idx + IDX_W'(1);
      end else begin
         w_load_idx = r_idx;
      end
      w_entry = f_entry(w_load_idx);
   end

   // Sequencer FSM; every output is registered and set on the edge entering its state.
   always_ff @(posedge i_apb_clk) begin
      if (i_apb_rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_gap_cnt   <= '0;
         r_acc_cnt   <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= 32'h0;
         r_pwdata    <= 32'h0;
         r_pstrb     <= 4'h0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
         r_init_err  <= 1'b0;
         r_err_idx   <= 8'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start && (N_INIT_REG == 0)) begin
                  r_state     <= ST_DONE;
                  r_init_done <= 1'b1;
               end else if (i_start) begin
                  r_state  <= ST_SETUP;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  r_psel   <= 1'b1;
                  r_pwrite <= 1'b1;
                  r_pstrb  <= 4'hF;
                  r_paddr  <= w_entry[63:32];
                  r_pwdata <= w_entry[31:0];
               end
            end
            ST_SETUP: begin
               r_state   <= ST_ACCESS;
               r_penable <= 1'b1;
               r_acc_cnt <= '0;
            end
            ST_ACCESS: begin
               if (i_pready || (r_acc_cnt == TO_W'(T_LAST))) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_pwrite  <= 1'b0;
                  r_paddr   <= 32'h0;
                  r_pwdata  <= 32'h0;
                  r_pstrb   <= 4'h0;
                  // A timed-out transfer and a slave error both count as failures.
                  if ((!i_pready || i_pslverr) && !r_init_err) begin
                     r_err_idx <= 8'(r_idx);
                  end
                  if (!i_pready || i_pslverr) begin
                     r_init_err <= 1'b1;
                  end
                  if (!i_pready || (r_idx == IDX_W'(N_LAST))) begin
                     r_state     <= ST_DONE;
                     r_busy      <= 1'b0;
                     r_init_done <= 1'b1;
                  end else if (GAP_CYCLES == 0) begin
                     r_idx     <= w_load_idx;
                     r_state   <= ST_SETUP;
                     r_psel    <= 1'b1;
                     r_pwrite  <= 1'b1;
                     r_pstrb   <= 4'hF;
                     r_paddr   <= w_entry[63:32];
                     r_pwdata  <= w_entry[31:0];
                  end else begin
                     r_idx     <= w_load_idx;
                     r_state   <= ST_GAP;
                     r_gap_cnt <= '0;
                  end
               end else begin
                  r_acc_cnt <= r_acc_cnt + TO_W'(1);
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_W'(G_LAST)) begin
                  r_state  <= ST_SETUP;
                  r_psel   <= 1'b1;
                  r_pwrite <= 1'b1;
                  r_pstrb  <= 4'hF;
                  r_paddr  <= w_entry[63:32];
                  r_pwdata <= w_entry[31:0];
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_psel      = r_psel;
   assign o_penable   = r_penable;
   assign o_pwrite    = r_pwrite;
   assign o_paddr     = r_paddr;
   assign o_pwdata    = r_pwdata;
   assign o_pstrb     = r_pstrb;
   assign o_busy      = r_busy;
   assign o_init_done = r_init_done;
   assign o_init_err  = r_init_err;
   assign o_err_idx   = r_err_idx;

endmodule

// File: tb/tb_reg_init_seq.sv
// Bench for reg_init_seq: a 3-entry instance driven by a delay/error-programmable
// APB responder and compared against a transfer-level model, plus an empty-table instance.
module tb_reg_init_seq;

   localparam int N   = 3;
   localparam int GAP = 2;
   localparam int TO  = 8;
   localparam logic [63:0] TAB [3] = '{64'h1000_0000_0000_0001,
                                       64'h2000_0000_0000_0002,
                                       64'h3000_0000_0000_0003};

   typedef struct packed {
      logic [2:0][7:0] dly;
      logic [2:0]      err;
      logic [7:0]      n;
      logic            e;
      logic [7:0]      eidx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic        o_psel, o_penable, o_pwrite, o_busy, o_init_done, o_init_err;
   logic [31:0] o_paddr, o_pwdata;
   logic [3:0]  o_pstrb;
   logic [7:0]  o_err_idx;

   logic        start0 = 1'b0;
   logic        tie0 = 1'b0;
   logic        o_psel0, o_penable0, o_pwrite0, o_busy0, o_init_done0, o_init_err0;
   logic [31:0] o_paddr0, o_pwdata0;
   logic [3:0]  o_pstrb0;
   logic [7:0]  o_err_idx0;

   always #5 clk = ~clk;

   reg_init_seq #(.N_INIT_REG(N), .INIT_TABLE(TAB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut (
      .i_apb_clk(clk), .i_apb_rst(rst), .i_start(start),
      .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
      .o_paddr(o_paddr), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
      .i_pready(pready), .i_pslverr(pslverr),
      .o_busy(o_busy), .o_init_done(o_init_done), .o_init_err(o_init_err), .o_err_idx(o_err_idx));

   reg_init_seq #(.N_INIT_REG(0), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut0 (
      .i_apb_clk(clk), .i_apb_rst(rst), .i_start(start0),
      .o_psel(o_psel0), .o_penable(o_penable0), .o_pwrite(o_pwrite0),
      .o_paddr(o_paddr0), .o_pwdata(o_pwdata0), .o_pstrb(o_pstrb0),
      .i_pready(tie0), .i_pslverr(tie0),
      .o_busy(o_busy0), .o_init_done(o_init_done0), .o_init_err(o_init_err0), .o_err_idx(o_err_idx0));

   // Per-entry responder programming (written by the stimulus, read by the responder)
   int          dly_a [3];
   logic        err_a [3];

   // Observed transfers
   int          mon_n, mon_acc, mon_idle, mon_bad_stable, mon_bad_attr;
   logic [31:0] mon_addr [8];
   logic [31:0] mon_data [8];
   int          mon_len [8];
   int          mon_gap [8];
   logic        psel0_seen = 1'b0;

   // Model results
   int          m_n, m_eidx;
   int          m_len [3];
   logic        m_e;

   int          total = 0;
   int          bad = 0;

   // Responder + monitor: runs on the falling edge, drives pready for the next rising edge.
   always @(negedge clk) begin
      int k;
      if (o_psel0) psel0_seen = 1'b1;
      if (rst) begin
         mon_n = 0; mon_acc = 0; mon_idle = 0; mon_bad_stable = 0; mon_bad_attr = 0;
         pready = 1'b0; pslverr = 1'b0;
      end else if (o_psel && !o_penable) begin
         if (mon_n < 8) begin
            mon_addr[mon_n] = o_paddr; mon_data[mon_n] = o_pwdata;
            mon_gap[mon_n] = mon_idle; mon_len[mon_n] = 0;
         end
         if (!o_pwrite || o_pstrb != 4'hF || !o_busy) mon_bad_attr++;
         mon_n++; mon_idle = 0; mon_acc = 0;
         pready = 1'($urandom); pslverr = 1'($urandom);
      end else if (o_psel && o_penable) begin
         mon_acc++;
         k = mon_n - 1;
         if (k >= 0 && k < 8) begin
            mon_len[k] = mon_acc;
            if (o_paddr != mon_addr[k] || o_pwdata != mon_data[k] || o_pstrb != 4'hF
                || !o_pwrite || !o_busy) mon_bad_stable++;
         end
         if (k >= 0 && k < N) begin
            pready = (mon_acc > dly_a[k]);
            pslverr = pready && err_a[k];
         end else begin
            pready = 1'b1; pslverr = 1'b0;
         end
      end else begin
         mon_idle++;
         if (o_penable || o_pwrite || o_paddr != 32'h0 || o_pwdata != 32'h0 || o_pstrb != 4'h0)
            mon_bad_attr++;
         pready = 1'($urandom); pslverr = 1'($urandom);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfer-level reference: each entry waits dly+1 cycles unless that exceeds the timeout.
   task automatic model();
      m_n = 0; m_e = 1'b0; m_eidx = 0;
      for (int i = 0; i < N; i++) begin
         m_n++;
         if (dly_a[i] >= TO) begin
            m_len[i] = TO;
            if (!m_e) m_eidx = i;
            m_e = 1'b1;
            break;
         end
         m_len[i] = dly_a[i] + 1;
         if (err_a[i] && !m_e) m_eidx = i;
         if (err_a[i]) m_e = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; start0 = 1'b0;
      repeat (3) tick();
      chk("rst_psel", o_psel, 0);
      chk("rst_penable", o_penable, 0);
      chk("rst_paddr", o_paddr, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_init_done, 0);
      chk("rst_err", o_init_err, 0);
      chk("rst_err_idx", o_err_idx, 0);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (!o_init_done && cyc < 300) begin
         tick();
         cyc++;
      end
      chk({tag, "_done_in_time"}, o_init_done, 1);
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_nwrites"}, mon_n, m_n);
      chk({tag, "_err"}, o_init_err, m_e);
      chk({tag, "_err_idx"}, o_err_idx, m_eidx);
      chk({tag, "_busy_end"}, o_busy, 0);
      chk({tag, "_psel_end"}, o_psel, 0);
      chk({tag, "_stable"}, mon_bad_stable, 0);
      chk({tag, "_attrs"}, mon_bad_attr, 0);
      for (int i = 0; i < m_n && i < mon_n; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), mon_addr[i], TAB[i][63:32]);
         chk($sformatf("%s_data%0d", tag, i), mon_data[i], TAB[i][31:0]);
         chk($sformatf("%s_len%0d", tag, i), mon_len[i], m_len[i]);
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), mon_gap[i], GAP);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v, input bit hand, input bit pulse);
      for (int i = 0; i < N; i++) begin
         dly_a[i] = int'(v.dly[i]);
         err_a[i] = v.err[i];
      end
      model();
      do_reset();
      tick();
      start = 1'b1;
      tick();
      if (pulse) start = 1'b0;
      wait_done(tag);
      repeat (2) tick();
      if (hand) begin
         chk({tag, "_tab_n"}, mon_n, v.n);
         chk({tag, "_tab_err"}, o_init_err, v.e);
         chk({tag, "_tab_eidx"}, o_err_idx, v.eidx);
      end
      check_result(tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      chk({tag, "_oneshot_n"}, mon_n, m_n);
      chk({tag, "_oneshot_done"}, o_init_done, 1);
   endtask

   function automatic vec_t mk(int d0, int d1, int d2, logic [2:0] e, int n, logic ee, int ei);
      vec_t v;
      v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2);
      v.err = e; v.n = 8'(n); v.e = ee; v.eidx = 8'(ei);
      return v;
   endfunction

   initial begin
      vec_t vecs [5];
      vec_t rv;
      int   cyc;
      vecs[0] = mk(0, 0, 0,   3'b000, 3, 1'b0, 0);  // plain sequence
      vecs[1] = mk(0, 5, 0,   3'b000, 3, 1'b0, 0);  // entry 1 waits 6 cycles
      vecs[2] = mk(0, 0, 0,   3'b110, 3, 1'b1, 1);  // slave errors on 1 and 2
      vecs[3] = mk(100, 0, 0, 3'b000, 1, 1'b1, 0);  // stuck on entry 0 -> abort
      vecs[4] = mk(0, 8, 7,   3'b000, 2, 1'b1, 1);  // timeout boundary on entry 1

      // Empty table: done the cycle after start, never selects.
      do_reset();
      tick();
      chk("n0_idle_done", o_init_done0, 0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("n0_done", o_init_done0, 1);
      chk("n0_busy", o_busy0, 0);
      repeat (3) tick();
      chk("n0_done_sticky", o_init_done0, 1);

      for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1, i[0]);

      // Entry 2 finishing exactly on the last allowed cycle, with an early error.
      run_vec("edge7", mk(0, 0, 7, 3'b001, 3, 1'b1, 0), 1'b1, 1'b0);

      // Reset during ACCESS of entry 1, then restart from entry 0.
      dly_a[0] = 0; dly_a[1] = 5; dly_a[2] = 0;
      err_a[0] = 1'b0; err_a[1] = 1'b0; err_a[2] = 1'b0;
      model();
      do_reset();
      tick();
      start = 1'b1;
      cyc = 0;
      while (!(mon_n == 2 && o_penable) && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("rstmid_reached", (mon_n == 2 && o_penable), 1);
      tick();
      rst = 1'b1;
      tick();
      chk("rstmid_psel", o_psel, 0);
      chk("rstmid_penable", o_penable, 0);
      chk("rstmid_busy", o_busy, 0);
      tick();
      rst = 1'b0;
      wait_done("rstmid");
      repeat (2) tick();
      check_result("rstmid");

      for (int r = 0; r < 12; r++) begin
         rv = mk(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                 3'($urandom), 0, 1'b0, 0);
         run_vec($sformatf("rnd%0d", r), rv, 1'b0, 1'($urandom));
      end

      chk("n0_never_psel", psel0_seen, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
